// File: rtl/sc_regshifter_pkg.sv
// Shared types and constants for the timed shift register.
package sc_regshifter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/sc_prescaler_tick.sv
// Prescaler: counts 0..PERIOD-1 while enabled and wraps to 0.
// tc_o strobes combinationally in the last count of each period.
// Synchronous clear has priority over enable.
module sc_prescaler_tick #(
    parameter int unsigned PERIOD = 4,
    parameter int unsigned CNT_W  = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = en_i && (cnt_q == TC_VAL);

    // Next count: clear, wrap at terminal count, or increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == TC_VAL) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sc_regshifter_timed.sv
// Timed shift register feeding the general register stage.
// Optional feature macro: RegSHIFTER_ROTATE_EN (rotate instead of zero-fill;
// runs then end only by stop or clear).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; prescaler held at 0
// RUN   | prescaler running, one shift per PERIOD cycles
// DONE  | one cycle after a shift emptied the register, then IDLE
module sc_regshifter_timed
    import sc_regshifter_pkg::*;
#(
    parameter int unsigned RegSHIFTER_DATAWIDTH = 8,
    parameter int unsigned RegSHIFTER_PERIOD    = 12500000
) (
    input  logic                            SC_RegSHIFTER_CLOCK_50,
    input  logic                            SC_RegSHIFTER_RESET_InLow,
    input  logic                            SC_RegSHIFTER_clear_InLow,
    input  logic                            SC_RegSHIFTER_load_InLow,
    input  logic                            SC_RegSHIFTER_start_InHigh,
    input  logic                            SC_RegSHIFTER_stop_InHigh,
    input  logic                            SC_RegSHIFTER_dir_InHigh,
    input  logic [RegSHIFTER_DATAWIDTH-1:0] SC_RegSHIFTER_data_InBUS,
    output logic [RegSHIFTER_DATAWIDTH-1:0] SC_RegSHIFTER_data_OutBUS,
    output logic                            SC_RegSHIFTER_tick_Out,
    output logic                            SC_RegSHIFTER_done_Out,
    output logic                            SC_RegSHIFTER_running_Out
);

    localparam int unsigned W     = RegSHIFTER_DATAWIDTH;
    localparam int unsigned CNT_W = (RegSHIFTER_PERIOD > 1) ? $clog2(RegSHIFTER_PERIOD) : 1;

    state_t         state_q, state_d;
    logic [W-1:0]   data_q, data_d;
    logic           tick_q, tick_d;
    logic           done_q, done_d;
    logic           running_q, running_d;

    logic           presc_en;
    logic           presc_clr;
    logic           presc_tc;
    logic           fill_left;
    logic           fill_right;
    logic [W-1:0]   shifted;
    logic           shift_ends_run;

    // The prescaler only advances in RUN when no higher-priority command is
    // present; clear, load and stop all restart the period from zero.
    assign presc_en  = SC_RegSHIFTER_clear_InLow && SC_RegSHIFTER_load_InLow &&
                       !SC_RegSHIFTER_stop_InHigh && (state_q == RUN);
    assign presc_clr = !presc_en;

    sc_prescaler_tick #(
        .PERIOD (RegSHIFTER_PERIOD),
        .CNT_W  (CNT_W)
    ) u_prescaler (
        .clk_i   (SC_RegSHIFTER_CLOCK_50),
        .rst_n_i (SC_RegSHIFTER_RESET_InLow),
        .en_i    (presc_en),
        .clr_i   (presc_clr),
        .tc_o    (presc_tc)
    );

`ifdef RegSHIFTER_ROTATE_EN
    assign fill_left      = data_q[W-1];
    assign fill_right     = data_q[0];
    assign shift_ends_run = 1'b0;
`else
    assign fill_left      = 1'b0;
    assign fill_right     = 1'b0;
    assign shift_ends_run = (shifted == '0);
`endif

    // One-position shift in the currently requested direction.
    always_comb begin
        shifted = data_q;
        if (SC_RegSHIFTER_dir_InHigh == DIR_LEFT) begin
            shifted = {data_q[W-2:0], fill_left};
        end else begin
            shifted = {fill_right, data_q[W-1:1]};
        end
    end

    // Next state, register contents and pulses; clear > load > stop > start/shift.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        if (!SC_RegSHIFTER_clear_InLow) begin
            state_d = IDLE;
            data_d  = '0;
        end else if (!SC_RegSHIFTER_load_InLow) begin
            data_d = SC_RegSHIFTER_data_InBUS;
            // DONE is a single-cycle state even when a load lands on it.
            if (state_q == DONE) begin
                state_d = IDLE;
            end
        end else if (SC_RegSHIFTER_stop_InHigh) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (SC_RegSHIFTER_start_InHigh && (data_q != '0)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (presc_tc) begin
                        data_d = shifted;
                        tick_d = 1'b1;
                        if (shift_ends_run) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        running_d = (state_d == RUN);
    end

    // State and registered outputs with asynchronous reset.
    always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or negedge SC_RegSHIFTER_RESET_InLow) begin
        if (!SC_RegSHIFTER_RESET_InLow) begin
            state_q   <= IDLE;
            data_q    <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    assign SC_RegSHIFTER_data_OutBUS = data_q;
    assign SC_RegSHIFTER_tick_Out    = tick_q;
    assign SC_RegSHIFTER_done_Out    = done_q;
    assign SC_RegSHIFTER_running_Out = running_q;

endmodule

// File: tb/tb_sc_regshifter_timed.sv
// Scoreboard bench for sc_regshifter_timed (DATAWIDTH 8, PERIOD 4).
module tb_sc_regshifter_timed;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear_n;
    logic       load_n;
    logic       start;
    logic       stop;
    logic       dir;
    logic [7:0] din;
    logic [7:0] dout;
    logic       tick;
    logic       done;
    logic       running;

    always #5 clk = ~clk;

    sc_regshifter_timed #(
        .RegSHIFTER_DATAWIDTH (8),
        .RegSHIFTER_PERIOD    (P)
    ) dut (
        .SC_RegSHIFTER_CLOCK_50     (clk),
        .SC_RegSHIFTER_RESET_InLow  (rst_n),
        .SC_RegSHIFTER_clear_InLow  (clear_n),
        .SC_RegSHIFTER_load_InLow   (load_n),
        .SC_RegSHIFTER_start_InHigh (start),
        .SC_RegSHIFTER_stop_InHigh  (stop),
        .SC_RegSHIFTER_dir_InHigh   (dir),
        .SC_RegSHIFTER_data_InBUS   (din),
        .SC_RegSHIFTER_data_OutBUS  (dout),
        .SC_RegSHIFTER_tick_Out     (tick),
        .SC_RegSHIFTER_done_Out     (done),
        .SC_RegSHIFTER_running_Out  (running)
    );

    typedef struct {
        int         edge_no;
        logic [7:0] data;
        logic       done;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         edge_cnt = 0;
    int         done_seen = 0;
    bit         mon_en = 0;

    // Reference model: register value, running flag, edge of the next shift.
    logic [7:0] m_data = 8'h00;
    bit         m_run = 0;
    int         m_next = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [7:0] shift_ref(input logic [7:0] v, input logic left);
        logic [7:0] r;
        if (left) r = v << 1;
        else      r = v >> 1;
`ifdef RegSHIFTER_ROTATE_EN
        if (left) r = r | (v >> 7);
        else      r = r | (v << 7);
`endif
        return r;
    endfunction

    // Apply the behavioural rules for one rising edge using the pre-edge inputs.
    task automatic model_edge();
        ev_t        ev;
        logic [7:0] nxt;
        edge_cnt++;
        if (!rst_n) begin
            m_data = 8'h00;
            m_run  = 0;
            exp_q.delete();
            return;
        end
        if (!clear_n) begin
            m_data = 8'h00;
            m_run  = 0;
        end else if (!load_n) begin
            m_data = din;
            if (m_run) m_next = edge_cnt + P;
        end else if (stop) begin
            m_run = 0;
        end else if (!m_run) begin
            if (start && m_data != 8'h00) begin
                m_run  = 1;
                m_next = edge_cnt + P;
            end
        end else if (edge_cnt == m_next) begin
            nxt        = shift_ref(m_data, dir);
            m_data     = nxt;
            ev.edge_no = edge_cnt;
            ev.data    = nxt;
`ifdef RegSHIFTER_ROTATE_EN
            ev.done    = 1'b0;
`else
            ev.done    = (nxt == 8'h00);
`endif
            exp_q.push_back(ev);
            if (ev.done) m_run = 0;
            else         m_next = edge_cnt + P;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Monitor: per-cycle state compare plus scoreboard pop on tick/done.
    always @(negedge clk) begin
        ev_t ev;
        bit  exp_ev;
        if (mon_en) begin
            chk("data", dout, m_data);
            chk("running", running, m_run);
            exp_ev = (exp_q.size() > 0) && (exp_q[0].edge_no == edge_cnt);
            if (done) done_seen++;
            if (tick || done || exp_ev) begin
                if (!exp_ev) begin
                    chk("unexpected_tick_done", {tick, done}, 2'b00);
                end else begin
                    ev = exp_q.pop_front();
                    chk("tick", tick, 1'b1);
                    chk("event_data", dout, ev.data);
                    chk("event_done", done, ev.done);
                end
            end
        end
    end

    initial begin
        int exp_done;
        rst_n   = 1'b1;
        clear_n = 1'b1;
        load_n  = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        dir     = 1'b0;
        din     = 8'h00;
        #2 rst_n = 1'b0;
        run(3);
        chk("reset_data", dout, 8'h00);
        chk("reset_tick", tick, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_running", running, 1'b0);
        mon_en = 1;
        rst_n  = 1'b1;
        run(2);

        // Left zero-fill walk of 8'h81 until the register empties.
        load_n = 1'b0; din = 8'h81; step();
        load_n = 1'b1; dir = 1'b1; start = 1'b1; step();
        start = 1'b0;
        done_seen = 0;
        run(40);
`ifdef RegSHIFTER_ROTATE_EN
        exp_done = 0;
`else
        exp_done = 1;
`endif
        chk("walk_done_count", done_seen, exp_done);
        stop = 1'b1; step(); stop = 1'b0; run(2);

        // Right walk / rotation of 8'h81, then stop.
        load_n = 1'b0; din = 8'h81; step();
        load_n = 1'b1; dir = 1'b0; start = 1'b1; step();
        start = 1'b0;
        run(33);
        stop = 1'b1; step(); stop = 1'b0; run(3);

        // Load at prescaler count 2 restarts the period.
        load_n = 1'b0; din = 8'h81; step();
        load_n = 1'b1; dir = 1'b1; start = 1'b1; step();
        start = 1'b0; run(2);
        load_n = 1'b0; din = 8'h3C; step();
        load_n = 1'b1; run(12);
        start = 1'b1; step(); start = 1'b0; run(3);
        stop = 1'b1; step(); stop = 1'b0; run(2);

        // start and stop together; clear and load together.
        load_n = 1'b0; din = 8'hA5; step(); load_n = 1'b1;
        start = 1'b1; stop = 1'b1; step();
        start = 1'b0; stop = 1'b0; run(3);
        clear_n = 1'b0; load_n = 1'b0; din = 8'hFF; step();
        clear_n = 1'b1; load_n = 1'b1; run(2);

        // Start with an empty register.
        start = 1'b1; step(); start = 1'b0; run(6);

        // Asynchronous reset mid-run.
        load_n = 1'b0; din = 8'h81; step();
        load_n = 1'b1; dir = 1'b1; start = 1'b1; step();
        start = 1'b0; run(6);
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", dout, 8'h00);
        chk("async_rst_tick", tick, 1'b0);
        chk("async_rst_done", done, 1'b0);
        chk("async_rst_running", running, 1'b0);
        m_data = 8'h00; m_run = 0; exp_q.delete();
        run(2);
        rst_n = 1'b1; step();
        start = 1'b1; step(); start = 1'b0; run(6);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            clear_n = ($urandom_range(0, 99) >= 2);
            load_n  = ($urandom_range(0, 99) >= 6);
            stop    = ($urandom_range(0, 99) < 3);
            start   = ($urandom_range(0, 99) < 15);
            dir     = 1'($urandom_range(0, 1));
            din     = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            step();
        end
        clear_n = 1'b1; load_n = 1'b1; stop = 1'b0; start = 1'b0;
        run(40);
        @(negedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_regshifter_timed.md
# sc_regshifter_timed

Timed shift register that sits directly upstream of the general register stage: it holds a pattern, shifts it one position left or right every programmable number of clock cycles, and drives its output bus into one of the general register's OR'd input buses. A small three-state controller handles start, stop and auto-completion, and reports each shift and the end of a run to the control FSM.

## Interface
- RegSHIFTER_DATAWIDTH, 8: width of the data buses.
- RegSHIFTER_PERIOD, 12500000: clock cycles between shifts while running (4 shifts/s at 50 MHz); legal range ≥ 1.
- SC_RegSHIFTER_CLOCK_50  in  1  single system clock, all logic on rising edge.
- SC_RegSHIFTER_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_RegSHIFTER_clear_InLow  in  1  synchronous clear, active low.
- SC_RegSHIFTER_load_InLow  in  1  synchronous parallel load, active low.
- SC_RegSHIFTER_start_InHigh  in  1  begin timed shifting.
- SC_RegSHIFTER_stop_InHigh  in  1  abort timed shifting.
- SC_RegSHIFTER_dir_InHigh  in  1  1 = shift toward MSB (left), 0 = toward LSB (right); sampled at each shift.
- SC_RegSHIFTER_data_InBUS  in  DATAWIDTH  pattern for parallel load.
- SC_RegSHIFTER_data_OutBUS  out  DATAWIDTH  current register contents.
- SC_RegSHIFTER_tick_Out  out  1  one-cycle pulse, high in the cycle the shifted value first appears.
- SC_RegSHIFTER_done_Out  out  1  one-cycle pulse when a run self-terminates.
- SC_RegSHIFTER_running_Out  out  1  high while in RUN.

## Operation
- States: IDLE, RUN, DONE. In IDLE the prescaler is held at 0.
- IDLE -> RUN on start, unless the register is zero. If the register is zero, start is ignored.
- In RUN, the prescaler counts 0..PERIOD-1. At count PERIOD-1 the register shifts one position and the prescaler wraps to 0.
- Without the rotate feature, a 0 is shifted in and the exiting bit is discarded. A shift whose result is all-zero moves the FSM RUN -> DONE. DONE lasts exactly one cycle, then the FSM returns to IDLE.
- RUN -> IDLE on stop. No done pulse is generated.
- Per-cycle priority: clear > load > stop > start/shift.
  - clear: register 0, prescaler 0, state IDLE, no done pulse.
  - load: register <= data_InBUS, prescaler 0, state unchanged. A load of zero while in RUN does not trigger DONE, because no shift occurred.
- start and stop in the same cycle: stop wins, state stays IDLE.
- start while already in RUN: ignored; the prescaler is not restarted.

## Timing
- Every output is registered. After reset: data_OutBUS = 0, tick_Out = 0, done_Out = 0, running_Out = 0, state IDLE, prescaler 0.
- Reset takes effect immediately and asynchronously, including mid-run. Release is synchronous to the clock.
- Start accepted at edge N: running_Out is high from N.
- The first shift occurs at edge N+PERIOD, and subsequent shifts every PERIOD edges.
- tick_Out is high for the single cycle following each shift edge. With PERIOD = 1 it stays high continuously while running.
- done_Out is high in the same cycle that the zero data and running_Out = 0 first appear.
- Load or clear takes effect at the next edge. After a load in RUN, the next shift is PERIOD edges later.

## Configuration
- RegSHIFTER_ROTATE_EN defined: shifting becomes rotation; the exiting bit re-enters at the opposite end. The register never reaches zero by shifting, so DONE is never entered from RUN and done_Out stays 0. Runs end only by stop or clear.
- RegSHIFTER_ROTATE_EN undefined: zero-fill shifting with auto-completion, as described in Operation.

## Structure
- Shared package sc_regshifter_pkg holds:
  - state typedef: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10;
  - direction constants DIR_LEFT = 1'b1 and DIR_RIGHT = 1'b0.
- Prescaler width is $clog2(PERIOD) with a minimum of 1, computed inside the module.
- One sub-module is natural: sc_prescaler_tick. It is a counter with enable and synchronous clear that emits a terminal-count strobe; it is instantiated once.

## Test plan
All scenarios use DATAWIDTH = 8 and PERIOD = 4.
- Load 8'h81, start, dir = 1, no ROTATE_EN -> data 8'h02, 04, 08, 10, 20, 40, 80, 00 at 4-cycle spacing. tick_Out pulses each shift. done_Out pulses once with the 8'h00 value, and running_Out falls in the same cycle.
- ROTATE_EN, load 8'h81, dir = 0, start -> 8'hC0, 60, 30, 18, 0C, 06, 03, 81 after 8 shifts. done_Out stays 0 throughout. stop -> running_Out = 0 next edge, data held at its current value.
- RUN at prescaler count 2, load 8'h3C -> data 8'h3C next edge, next shift exactly 4 edges after the load edge, no tick during the interval.
- start and stop in the same cycle -> stays IDLE. clear and load in the same cycle with data 8'hFF -> data 8'h00.
- Register 8'h00, start -> running_Out stays 0, no tick_Out and no done_Out.
- Mid-run, drive RESET_InLow = 0 between edges -> all outputs 0 immediately. After release, start is ignored because the register is zero.
